// File: rtl/line_xfer_pkg.sv
// Shared types and constants for the cache-line transfer engine.
package line_xfer_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_OFS   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_GAP,
    ST_FILL_REQ,
    ST_DONE
  } state_e;

endpackage

// File: rtl/line_xfer_engine_sat_counter.sv
// Saturating up-counter used for the transfer statistics; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance on inc_i unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/line_xfer_engine.sv
// Memory-side initiator for the data cache: optional write-back of a dirty
// victim, then the allocate read, with an ack watchdog and statistics.
module line_xfer_engine
  import line_xfer_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wb_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [LINE_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LINE_W-1:0] fill_data_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  wb_cnt_o,
  output logic [CNT_W-1:0]  fill_cnt_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  // Clearing the offset bits by mask keeps every address bit in use.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFS) - 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              wb_q;
  logic [LINE_W-1:0] fill_data_q;
  logic              mem_enable_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_data_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [WD_W-1:0]   wd_q;

  logic wd_hit;
  logic wb_inc;
  logic fill_inc;

  // Watchdog expires on the last permitted request cycle; an ack in the same cycle takes priority.
  assign wd_hit   = (wd_q == WD_LAST);
  assign wb_inc   = (state_q == ST_WB_REQ)   && mem_ack_i;
  assign fill_inc = (state_q == ST_FILL_REQ) && mem_ack_i;

  // Sequencer: every output is registered so the memory port sees glitch-free, stable requests.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wb_q         <= 1'b0;
      fill_data_q  <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      fill_addr_q  <= '0;
      wd_q         <= '0;
    end else begin
      done_q <= 1'b0;
      wd_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            busy_q       <= 1'b1;
            wb_q         <= wb_i;
            fill_addr_q  <= fill_addr_i & LINE_MASK;
            mem_enable_q <= 1'b1;
            mem_write_q  <= wb_i;
            if (wb_i) begin
              mem_addr_q <= wb_addr_i & LINE_MASK;
              mem_data_q <= wb_data_i;
              state_q    <= ST_WB_REQ;
            end else begin
              mem_addr_q <= fill_addr_i & LINE_MASK;
              mem_data_q <= '0;
              state_q    <= ST_FILL_REQ;
            end
          end
        end
        ST_WB_REQ: begin
          if (mem_ack_i) begin
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            state_q      <= ST_GAP;
          end else if (wd_hit) begin
            // Write-back never completed: abandon the fill as well.
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            fill_data_q  <= '0;
            err_q        <= 1'b1;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_GAP: begin
          mem_enable_q <= 1'b1;
          mem_write_q  <= 1'b0;
          mem_addr_q   <= fill_addr_q;
          mem_data_q   <= '0;
          state_q      <= ST_FILL_REQ;
        end
        ST_FILL_REQ: begin
          if (mem_ack_i || wd_hit) begin
            mem_enable_q <= 1'b0;
            mem_addr_q   <= '0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_DONE;
            if (mem_ack_i) begin
              fill_data_q <= mem_data_i;
            end else begin
              fill_data_q <= '0;
              err_q       <= 1'b1;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_DONE: begin
          wb_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .inc_i  (wb_inc),
    .cnt_o  (wb_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fill_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .inc_i  (fill_inc),
    .cnt_o  (fill_cnt_o)
  );

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign fill_data_o  = fill_data_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_line_xfer_engine.sv
// Directed bench for line_xfer_engine with an inline memory responder.
// Statistics counters are built 3 bits wide so saturation is reached quickly.
module tb_line_xfer_engine;

  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = 7;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              req_i = 1'b0;
  logic              wb_i = 1'b0;
  logic [ADDR_W-1:0] wb_addr_i = '0;
  logic [LINE_W-1:0] wb_data_i = '0;
  logic [ADDR_W-1:0] fill_addr_i = '0;
  logic              busy_o;
  logic              done_o;
  logic [LINE_W-1:0] fill_data_o;
  logic              err_o;
  logic [CNT_W-1:0]  wb_cnt_o;
  logic [CNT_W-1:0]  fill_cnt_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_i = 1'b0;
  logic [LINE_W-1:0] mem_data_i = '0;

  always #5 clk_i = ~clk_i;

  line_xfer_engine #(
    .LINE_W  (LINE_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .wb_i         (wb_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .fill_addr_i  (fill_addr_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fill_data_o  (fill_data_o),
    .err_o        (err_o),
    .wb_cnt_o     (wb_cnt_o),
    .fill_cnt_o   (fill_cnt_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [LINE_W-1:0] R1, R2, R3, R4, AA, V55, ZL;
  int                gap;
  bit                stable;
  logic [ADDR_W-1:0] s_addr;
  logic              s_wr;
  logic [LINE_W-1:0] s_data;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request during an idle cycle; it is accepted on the next rising edge.
  task automatic start_req(input logic wb, input logic [ADDR_W-1:0] wa, input logic [LINE_W-1:0] wd,
                           input logic [ADDR_W-1:0] fa, input bit hold);
    req_i       = 1'b1;
    wb_i        = wb;
    wb_addr_i   = wa;
    wb_data_i   = wd;
    fill_addr_i = fa;
    @(posedge clk_i);
    #1;
    if (!hold) req_i = 1'b0;
  endtask

  // Responder: wait for enable (counting low cycles), record the request, check it
  // stays stable for lat cycles, and optionally ack in the last of them.
  task automatic serve(input int lat, input logic [LINE_W-1:0] rd, input bit give_ack,
                       output int g, output bit st, output logic [ADDR_W-1:0] a,
                       output logic w, output logic [LINE_W-1:0] d);
    g = 0;
    @(negedge clk_i);
    while (!mem_enable_o && g < 200) begin
      g++;
      @(negedge clk_i);
    end
    a  = mem_addr_o;
    w  = mem_write_o;
    d  = mem_data_o;
    st = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk_i);
      if (mem_enable_o !== 1'b1 || mem_addr_o !== a || mem_write_o !== w || mem_data_o !== d) st = 1'b0;
      if (k == lat && give_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = rd;
      end
    end
    @(posedge clk_i);
    #1;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  endtask

  initial begin
    R1  = {8{32'h1111_C0DE}};
    R2  = {8{32'h2222_BEEF}};
    R3  = {8{32'h3333_F00D}};
    R4  = {8{32'h4444_1234}};
    AA  = {32{8'hAA}};
    V55 = {32{8'h55}};
    ZL  = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fill_data", fill_data_o, ZL);
    chk("rst_wb_cnt", wb_cnt_o, 0);
    chk("rst_fill_cnt", fill_cnt_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Fill-only, 10-cycle responder
    start_req(1'b0, 32'h0, ZL, 32'h0000_0404, 1'b0);
    chk("f1_busy_rise", busy_o, 1);
    serve(10, R1, 1'b1, gap, stable, s_addr, s_wr, s_data);
    chk("f1_gap", gap, 0);
    chk("f1_addr", s_addr, 32'h400);
    chk("f1_write", s_wr, 0);
    chk("f1_stable", stable, 1);
    @(negedge clk_i);
    chk("f1_done", done_o, 1);
    chk("f1_busy", busy_o, 0);
    chk("f1_enable", mem_enable_o, 0);
    chk("f1_data", fill_data_o, R1);
    chk("f1_fill_cnt", fill_cnt_o, 1);
    chk("f1_wb_cnt", wb_cnt_o, 0);
    @(negedge clk_i);
    chk("f1_done_pulse", done_o, 0);
    chk("f1_data_held", fill_data_o, R1);

    // Dirty miss: write-back then fill
    start_req(1'b1, 32'h0000_002F, AA, 32'h0000_0417, 1'b0);
    serve(4, ZL, 1'b1, gap, stable, s_addr, s_wr, s_data);
    chk("d_wb_gap", gap, 0);
    chk("d_wb_addr", s_addr, 32'h20);
    chk("d_wb_write", s_wr, 1);
    chk("d_wb_data", s_data, AA);
    chk("d_wb_stable", stable, 1);
    serve(3, R2, 1'b1, gap, stable, s_addr, s_wr, s_data);
    chk("d_gap_cycles", gap, 1);
    chk("d_fill_addr", s_addr, 32'h400);
    chk("d_fill_write", s_wr, 0);
    chk("d_fill_stable", stable, 1);
    @(negedge clk_i);
    chk("d_done", done_o, 1);
    chk("d_data", fill_data_o, R2);
    chk("d_wb_cnt", wb_cnt_o, 1);
    chk("d_fill_cnt", fill_cnt_o, 2);
    @(negedge clk_i);

    // Ack in the last allowed cycle completes normally
    start_req(1'b0, 32'h0, ZL, 32'h0000_1000, 1'b0);
    serve(TIMEOUT, R3, 1'b1, gap, stable, s_addr, s_wr, s_data);
    chk("a64_stable", stable, 1);
    @(negedge clk_i);
    chk("a64_done", done_o, 1);
    chk("a64_err", err_o, 0);
    chk("a64_data", fill_data_o, R3);
    chk("a64_fill_cnt", fill_cnt_o, 3);
    @(negedge clk_i);

    // Fill never acked: abort after TIMEOUT cycles
    start_req(1'b0, 32'h0, ZL, 32'h0000_2000, 1'b0);
    serve(TIMEOUT, ZL, 1'b0, gap, stable, s_addr, s_wr, s_data);
    chk("to_held", stable, 1);
    @(negedge clk_i);
    chk("to_enable_drop", mem_enable_o, 0);
    chk("to_done", done_o, 1);
    chk("to_err", err_o, 1);
    chk("to_data_zero", fill_data_o, ZL);
    chk("to_fill_cnt", fill_cnt_o, 3);
    chk("to_wb_cnt", wb_cnt_o, 1);
    @(negedge clk_i);
    chk("to_err_sticky", err_o, 1);
    chk("to_done_pulse", done_o, 0);

    // Write-back never acked: fill is skipped
    start_req(1'b1, 32'h0000_0040, V55, 32'h0000_3000, 1'b0);
    serve(TIMEOUT, ZL, 1'b0, gap, stable, s_addr, s_wr, s_data);
    chk("wto_held", stable, 1);
    @(negedge clk_i);
    chk("wto_done", done_o, 1);
    chk("wto_wb_cnt", wb_cnt_o, 1);
    @(negedge clk_i);
    chk("wto_no_fill", mem_enable_o, 0);
    chk("wto_busy", busy_o, 0);
    chk("wto_fill_cnt", fill_cnt_o, 3);

    // Asynchronous reset three cycles into a write-back
    start_req(1'b1, 32'h0000_0020, V55, 32'h0000_0400, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("r_enable_pre", mem_enable_o, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("r_enable", mem_enable_o, 0);
    chk("r_write", mem_write_o, 0);
    chk("r_addr", mem_addr_o, 0);
    chk("r_data", mem_data_o, ZL);
    chk("r_busy", busy_o, 0);
    chk("r_err", err_o, 0);
    chk("r_wb_cnt", wb_cnt_o, 0);
    chk("r_fill_cnt", fill_cnt_o, 0);
    chk("r_fill_data", fill_data_o, ZL);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i      = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = R1;
    @(posedge clk_i);
    #1;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    @(negedge clk_i);
    chk("sp_enable", mem_enable_o, 0);
    chk("sp_busy", busy_o, 0);
    chk("sp_done", done_o, 0);
    chk("sp_fill_data", fill_data_o, ZL);
    chk("sp_fill_cnt", fill_cnt_o, 0);
    start_req(1'b0, 32'h0, ZL, 32'h0000_0404, 1'b0);
    serve(2, R4, 1'b1, gap, stable, s_addr, s_wr, s_data);
    chk("fr_addr", s_addr, 32'h400);
    @(negedge clk_i);
    chk("fr_done", done_o, 1);
    chk("fr_data", fill_data_o, R4);
    chk("fr_fill_cnt", fill_cnt_o, 1);
    chk("fr_wb_cnt", wb_cnt_o, 0);
    @(negedge clk_i);

    // req_i held high: one acceptance per sequence, counters saturate
    start_req(1'b1, 32'h0000_0080, AA, 32'h0000_0500, 1'b1);
    for (int i = 0; i < 9; i++) begin
      serve(1, ZL, 1'b1, gap, stable, s_addr, s_wr, s_data);
      chk("sat_wb_gap", gap, (i == 0) ? 0 : 1);
      chk("sat_wb_write", s_wr, 1);
      serve(1, R1, 1'b1, gap, stable, s_addr, s_wr, s_data);
      chk("sat_fill_gap", gap, 1);
      @(negedge clk_i);
      chk("sat_done", done_o, 1);
      chk("sat_wb_cnt", wb_cnt_o, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
      chk("sat_fill_cnt", fill_cnt_o, (i + 2 > CNT_MAX) ? CNT_MAX : i + 2);
      if (i == 8) req_i = 1'b0;
    end
    repeat (2) @(negedge clk_i);
    chk("sat_idle_enable", mem_enable_o, 0);
    chk("sat_idle_busy", busy_o, 0);
    chk("sat_wb_final", wb_cnt_o, CNT_MAX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_xfer_engine.md
# line_xfer_engine

Memory-side initiator for the data cache: it performs one cache-line transfer sequence at a time on the 256-bit enable/write/ack memory port and is the requester counterpart of the data memory responder.
- On a miss, the cache hands it an optional dirty victim plus a fill address; it issues the write-back, then the allocate read, and returns the fill line.
- It sits between the dcache controller and the memory port inside CPU.
- It also provides a per-request ack watchdog and saturating transfer statistics.

## Interface
- LINE_W, 256, line width in bits (memory beat = one full line)
- ADDR_W, 32, byte address width
- TIMEOUT, 64, max cycles enable_o may stay high without ack before abort
- CNT_W, 16, statistics counter width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- req_i  in  1  start a transfer sequence; sampled only when busy_o=0
- wb_i  in  1  victim is dirty; write-back precedes fill (sampled with req_i)
- wb_addr_i  in  ADDR_W  victim line byte address; bits [4:0] ignored and driven 0 on port
- wb_data_i  in  LINE_W  victim line data (captured at acceptance)
- fill_addr_i  in  ADDR_W  line to fetch; bits [4:0] forced 0 on port
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse: sequence finished
- fill_data_o  out  LINE_W  fetched line; valid from done_o and held until next acceptance
- err_o  out  1  sticky: a request timed out; cleared only by reset
- wb_cnt_o / fill_cnt_o  out  CNT_W  completed write-backs / fills, saturating at all-ones
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  memory byte address
- mem_data_o  out  LINE_W  write data
- mem_ack_i  in  1  responder completion, one-cycle pulse
- mem_data_i  in  LINE_W  read data, valid in the ack cycle

## Operation
- States: IDLE, WB_REQ, GAP, FILL_REQ, DONE.
- IDLE, req_i=1:
  - Capture addresses, wb_data_i and wb_i; set busy_o.
  - Go to WB_REQ if wb_i, else FILL_REQ.
- WB_REQ:
  - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={wb_addr[31:5],5'b0}, mem_data_o=victim data.
  - On mem_ack_i: increment wb_cnt, go to GAP.
- GAP:
  - mem_enable_o=0 for exactly one cycle; then FILL_REQ.
  - Every pair of back-to-back memory requests is separated by at least one low cycle.
- FILL_REQ:
  - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={fill_addr[31:5],5'b0}.
  - On mem_ack_i: register mem_data_i into fill_data_o, increment fill_cnt, go to DONE.
- DONE:
  - done_o=1, busy_o=0, mem_enable_o=0 for one cycle; then IDLE.
  - A new req_i is not accepted in DONE.
- Request signals (enable, write, addr, data) are held stable from assertion until the edge that samples mem_ack_i=1.
- mem_ack_i seen in IDLE, GAP or DONE is ignored.
- Watchdog:
  - Counts cycles in WB_REQ/FILL_REQ; cleared on every state entry.
  - Reaching TIMEOUT without ack:
    - Sets err_o and goes to DONE; the statistics counter for the aborted request is not incremented.
    - fill_data_o is forced to 0; a write-back timeout skips the fill.
  - Ack and timeout in the same cycle: ack wins, no error.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset (asynchronous, mid-operation included) gives:
  - state IDLE, all mem_* outputs 0, busy_o=0, done_o=0, err_o=0;
  - fill_data_o=0, counters 0;
  - an in-flight memory request is abandoned without completion.

## Timing
- Acceptance edge E0 → mem_enable_o high from E0.
- Responder acks on edge Ea (ack visible in cycle before Ea) → enable drops from Ea.
- Fill-only: done_o high in the cycle after the fill ack is sampled; latency = Lf + 1 cycles from acceptance, where Lf = cycles enable was high.
- Write-back + fill: latency = Lw + 1 (GAP) + Lf + 1.
- busy_o is registered and rises in the cycle after acceptance; earliest next acceptance is the edge after the DONE cycle.
- err_o rises in the same cycle as the aborting DONE.

## Structure
- Package line_xfer_pkg:
  - state enum;
  - LINE_W / ADDR_W defaults;
  - LINE_OFS = 5 (line offset bits).
- One sub-module, sat_counter (CNT_W, inc, async active-low clear), instantiated twice for the statistics.
- The watchdog counter stays inline.

## Test plan
- Fill-only against a responder with fixed 10-cycle ack, fill_addr=0x0000_0404: mem_addr_o=0x400 and write=0 for 10 cycles → done_o pulse, fill_data_o = responder line, fill_cnt=1, wb_cnt=0.
- Dirty miss with wb_addr=0x20, data=0xAA..AA, fill_addr=0x400:
  - write to 0x20 with data held stable until ack;
  - exactly 1 enable-low cycle;
  - read 0x400;
  - wb_cnt=1, fill_cnt=1.
- Ack never returned, TIMEOUT=64: enable drops after 64 cycles, err_o=1 sticky, done_o pulses, fill_data_o=0, counters unchanged.
- Ack on exactly the 64th cycle → normal completion, err_o stays 0.
- rst_i low 3 cycles into a write-back → all outputs 0 immediately (asynchronous); a spurious ack afterwards is ignored; a fresh request then completes.
- req_i held high continuously with wb_cnt preloaded to 0xFFFE:
  - one acceptance per sequence, none during busy_o or DONE;
  - wb_cnt saturates at 0xFFFF.
